// File: rtl/la_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : la_pkg
//  Description : Shared definitions for the logic-analyzer command controller.
//                Holds the host opcode enum, response byte constants, the
//                location of the capture-done flag and the controller state
//                encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package la_pkg;

    // Host opcode, taken from cmd[15:14]
    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_DUMP  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    localparam logic [7:0] ACK = 8'hA5;
    localparam logic [7:0] NAK = 8'hEE;

    // capture_done flag lives in the trigger configuration register
    localparam int TRIGCFG_ADDR = 0;
    localparam int CAPDONE_BIT  = 5;

    // Controller states
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_RESP      = 3'd1;
    localparam state_t ST_WAIT_SENT = 3'd2;
    localparam state_t ST_DUMP_RD   = 3'd3;
    localparam state_t ST_DUMP_SEND = 3'd4;
    localparam state_t ST_DUMP_WAIT = 3'd5;

endpackage : la_pkg
`default_nettype wire

// File: rtl/la_dump_seq.sv
`default_nettype none
// ============================================================================
//  Module      : la_dump_seq
//  Description : Capture RAM dump sequencer. Loads the oldest-sample address,
//                steps the read address modulo 2^AW and counts bytes sent.
//                'last' flags the final byte of a full-depth dump.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                load           - start a dump at start_addr, count = 0
//                start_addr     - address of the oldest sample
//                advance        - step to the next address / count
//                raddr          - capture RAM read address
//                last           - current byte is the 2^AW-th of the dump
//  Revision    : 1.0  initial release
// ============================================================================
module la_dump_seq #(
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [AW-1:0] start_addr,
    input  logic          advance,
    output logic [AW-1:0] raddr,
    output logic          last
);

    localparam logic [AW:0] c_last_count = {1'b0, {AW{1'b1}}};

    logic [AW-1:0] r_raddr;
    logic [AW:0]   r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_raddr <= '0;
            r_count <= '0;
        end else if (load) begin
            r_raddr <= start_addr;
            r_count <= '0;
        end else if (advance) begin
            // natural wrap of the AW-bit adder gives the modulo-depth address
            r_raddr <= r_raddr + 1'b1;
            r_count <= r_count + 1'b1;
        end
    end

    assign raddr = r_raddr;
    assign last  = (r_count == c_last_count);

endmodule : la_dump_seq
`default_nettype wire

// File: rtl/la_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : la_cmd_ctrl
//  Description : Logic-analyzer host command controller. Decodes 16-bit host
//                commands into config register reads/writes and, when built
//                with LA_DUMP_EN, streams a capture RAM channel to the host
//                byte by byte starting at the oldest sample.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                cmd, cmd_rdy      - host command and its valid level
//                clr_cmd_rdy       - pulse consuming cmd
//                resp, send_resp   - response byte and its launch pulse
//                resp_sent         - UART finished the response byte
//                set_capture_done  - sets regs[0] bit 5
//                cap_start_addr    - oldest sample address
//                raddr, rdata      - capture RAM read port (latency 1)
//                regs              - flattened config register file
//                busy              - controller not idle
//  Config      : LA_DUMP_EN - build the capture dump path
//  Revision    : 1.0  initial release
// ============================================================================
module la_cmd_ctrl
    import la_pkg::*;
#(
    parameter int NUM_CH   = 5,
    parameter int AW       = 9,
    parameter int NUM_REGS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           cmd,
    input  logic                  cmd_rdy,
    output logic                  clr_cmd_rdy,
    output logic [7:0]            resp,
    output logic                  send_resp,
    input  logic                  resp_sent,
    input  logic                  set_capture_done,
    input  logic [AW-1:0]         cap_start_addr,
    output logic [AW-1:0]         raddr,
    input  logic [NUM_CH*8-1:0]   rdata,
    output logic [NUM_REGS*8-1:0] regs,
    output logic                  busy
);

    state_t     r_state;
    logic [7:0] r_resp;
    logic       r_send_resp;
    logic       r_clr_cmd_rdy;
    logic [7:0] r_regs [NUM_REGS];

    op_e        w_op;
    logic [5:0] w_idx;
    logic [7:0] w_data;
    logic       w_accept;
    logic       w_reg_ok;
    logic       w_wr_en;
    logic       w_is_dump;
    logic [7:0] w_rd_val;
    logic [7:0] w_dec_resp;

    assign w_op     = op_e'(cmd[15:14]);
    assign w_idx    = cmd[13:8];
    assign w_data   = cmd[7:0];
    assign w_accept = (r_state == ST_IDLE) && cmd_rdy;
    assign w_reg_ok = (32'(w_idx) < NUM_REGS);
    assign w_wr_en  = w_accept && (w_op == OP_WRITE) && w_reg_ok;

    always_comb begin
        w_rd_val = 8'h00;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (w_idx == 6'(r)) w_rd_val = r_regs[r];
        end
    end

    // Response for every non-dump command (a valid dump bypasses this)
    always_comb begin
        w_dec_resp = NAK;
        case (w_op)
            OP_READ:  w_dec_resp = w_reg_ok ? w_rd_val : NAK;
            OP_WRITE: w_dec_resp = w_reg_ok ? ACK : NAK;
            default:  w_dec_resp = NAK;
        endcase
    end

`ifdef LA_DUMP_EN
    logic [5:0] r_idx;
    logic       w_seq_adv;
    logic       w_last;
    logic [7:0] w_ch_byte;

    assign w_is_dump = (w_op == OP_DUMP) && (32'(w_idx) < NUM_CH);
    assign w_seq_adv = (r_state == ST_DUMP_WAIT) && resp_sent && !w_last;

    always_comb begin
        w_ch_byte = 8'h00;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_idx == 6'(c)) w_ch_byte = rdata[8*c +: 8];
        end
    end

    la_dump_seq #(
        .AW         (AW)
    ) u_dump_seq (
        .clk        (clk),
        .rst        (rst),
        .load       (w_accept && w_is_dump),
        .start_addr (cap_start_addr),
        .advance    (w_seq_adv),
        .raddr      (raddr),
        .last       (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst)           r_idx <= '0;
        else if (w_accept) r_idx <= w_idx;
    end
`else
    logic w_unused_ok;

    assign w_is_dump   = 1'b0;
    assign raddr       = '0;
    assign w_unused_ok = ^{rdata, cap_start_addr};
`endif

    // Register file; the capture-done set is applied after the host write so
    // a simultaneous write keeps bit 5 set while the other bits take data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) r_regs[r] <= 8'h00;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (w_wr_en && (w_idx == 6'(r))) r_regs[r] <= w_data;
            end
            if (set_capture_done) r_regs[TRIGCFG_ADDR][CAPDONE_BIT] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_resp        <= 8'h00;
            r_send_resp   <= 1'b0;
            r_clr_cmd_rdy <= 1'b0;
        end else begin
            r_send_resp   <= 1'b0;
            r_clr_cmd_rdy <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_rdy) begin
                        r_clr_cmd_rdy <= 1'b1;
                        if (w_is_dump) begin
                            r_state <= ST_DUMP_RD;
                        end else begin
                            r_resp  <= w_dec_resp;
                            r_state <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    r_send_resp <= 1'b1;
                    r_state     <= ST_WAIT_SENT;
                end
                ST_WAIT_SENT: begin
                    if (resp_sent) r_state <= ST_IDLE;
                end
`ifdef LA_DUMP_EN
                // one idle cycle lets the RAM present rdata for raddr
                ST_DUMP_RD: r_state <= ST_DUMP_SEND;
                ST_DUMP_SEND: begin
                    r_resp      <= w_ch_byte;
                    r_send_resp <= 1'b1;
                    r_state     <= ST_DUMP_WAIT;
                end
                ST_DUMP_WAIT: begin
                    if (resp_sent) r_state <= w_last ? ST_IDLE : ST_DUMP_RD;
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_regs
        assign regs[8*r +: 8] = r_regs[r];
    end

    assign resp        = r_resp;
    assign send_resp   = r_send_resp;
    assign clr_cmd_rdy = r_clr_cmd_rdy;
    assign busy        = (r_state != ST_IDLE);

endmodule : la_cmd_ctrl
`default_nettype wire

// File: tb/tb_la_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_la_cmd_ctrl
//  Description : Self-checking bench for la_cmd_ctrl (NUM_CH=5, AW=3,
//                NUM_REGS=16). A transaction-level model predicts the register
//                file, accept pulses, busy and the ordered response bytes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_la_cmd_ctrl;

    localparam int NUM_CH   = 5;
    localparam int AW       = 3;
    localparam int NUM_REGS = 16;
    localparam int DEPTH    = 1 << AW;
`ifdef LA_DUMP_EN
    localparam bit DUMP_ON = 1'b1;
`else
    localparam bit DUMP_ON = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [15:0]           cmd = '0;
    logic                  cmd_rdy = 1'b0;
    logic                  clr_cmd_rdy;
    logic [7:0]            resp;
    logic                  send_resp;
    logic                  resp_sent = 1'b0;
    logic                  set_capture_done = 1'b0;
    logic [AW-1:0]         cap_start_addr = 3'd6;
    logic [AW-1:0]         raddr;
    logic [NUM_CH*8-1:0]   rdata = '0;
    logic [NUM_REGS*8-1:0] regs;
    logic                  busy;

    la_cmd_ctrl #(.NUM_CH(NUM_CH), .AW(AW), .NUM_REGS(NUM_REGS)) dut (
        .clk(clk), .rst(rst), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp),
        .resp_sent(resp_sent), .set_capture_done(set_capture_done),
        .cap_start_addr(cap_start_addr), .raddr(raddr), .rdata(rdata),
        .regs(regs), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Capture RAM: channel 2 holds addr*0x11, others random; read latency 1
    logic [7:0] ram [NUM_CH][DEPTH];
    initial begin
        for (int c = 0; c < NUM_CH; c++)
            for (int a = 0; a < DEPTH; a++)
                ram[c][a] = (c == 2) ? 8'(a * 17) : 8'($urandom);
    end
    always @(posedge clk)
        for (int c = 0; c < NUM_CH; c++) rdata[8*c +: 8] <= ram[c][raddr];

    // UART model: logs every launched byte, acknowledges after 0..3 cycles
    logic [7:0] rx_q[$];
    bit u_pending = 1'b0;
    int u_delay = 0;
    always @(negedge clk) begin
        resp_sent = 1'b0;
        if (u_pending) begin
            if (u_delay == 0) begin resp_sent = 1'b1; u_pending = 1'b0; end
            else u_delay--;
        end
        if (send_resp) begin
            chk("send_without_resp_sent", u_pending, 1'b0);
            u_pending = 1'b1;
            u_delay = $urandom_range(0, 3);
            rx_q.push_back(resp);
        end
    end

    // Transaction-level model, evaluated on pre-edge input values
    logic [7:0] m_regs [NUM_REGS];
    logic [7:0] exp_q[$];
    bit m_busy = 1'b0, m_clr = 1'b0;
    int m_left = 0;
    always @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) m_regs[r] = 8'h00;
            exp_q.delete(); m_busy = 1'b0; m_clr = 1'b0; m_left = 0;
        end else begin
            m_clr = 1'b0;
            if (!m_busy && cmd_rdy) begin
                int op, idx;
                op = int'(cmd[15:14]); idx = int'(cmd[13:8]);
                m_clr = 1'b1; m_busy = 1'b1;
                if (op == 0 && idx < NUM_REGS) exp_q.push_back(m_regs[idx]);
                else if (op == 1 && idx < NUM_REGS) begin
                    m_regs[idx] = cmd[7:0]; exp_q.push_back(8'hA5);
                end else if (op == 2 && DUMP_ON && idx < NUM_CH) begin
                    for (int i = 0; i < DEPTH; i++)
                        exp_q.push_back(ram[idx][(int'(cap_start_addr) + i) % DEPTH]);
                end else exp_q.push_back(8'hEE);
                m_left = exp_q.size();
            end else if (m_busy && resp_sent) begin
                m_left--;
                if (m_left == 0) m_busy = 1'b0;
            end
            if (set_capture_done) m_regs[0][5] = 1'b1;
        end
    end

    // Compare process
    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            logic [127:0] exp_regs;
            for (int r = 0; r < NUM_REGS; r++) exp_regs[8*r +: 8] = m_regs[r];
            chk("regs", regs, exp_regs);
            chk("clr_cmd_rdy", clr_cmd_rdy, m_clr);
            chk("busy", busy, m_busy);
            if (!DUMP_ON) chk("raddr_tied", raddr, 0);
            if (send_resp) begin
                if (exp_q.size() == 0) chk("unexpected_send_resp", 1, 0);
                else chk("resp", resp, exp_q.pop_front());
            end
        end
    end

    task automatic issue(input logic [15:0] c, input bit cap);
        int t = 0;
        @(negedge clk);
        cmd = c; cmd_rdy = 1'b1; set_capture_done = cap;
        do begin @(negedge clk); set_capture_done = 1'b0; t++; end
        while (!clr_cmd_rdy && t < 500);
        cmd_rdy = 1'b0;
        if (!clr_cmd_rdy) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int t = 0;
        do begin @(negedge clk); t++; end while (busy && t < 500);
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    logic [7:0] dump_exp [8] = '{8'h66, 8'h77, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    initial begin
        int base;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_regs", regs, 0);
        chk("reset_resp", resp, 0);
        chk("reset_raddr", raddr, 0);
        chk("reset_ctrl", {busy, send_resp, clr_cmd_rdy}, 0);
        chk_en = 1'b1;

        // write / read back
        base = rx_q.size();
        issue(16'h4312, 0); wait_idle();
        chk("write_ack", rx_q[base], 8'hA5);
        chk("regs3", regs[31:24], 8'h12);
        issue(16'h0300, 0); wait_idle();
        chk("read_back", rx_q[base+1], 8'h12);

        // bad index / reserved op
        issue(16'h7F00, 0); wait_idle();
        chk("bad_idx_nak", rx_q[base+2], 8'hEE);
        chk("bad_idx_regs", regs, 128'h12 << 24);
        issue(16'hC000, 0); wait_idle();
        chk("rsvd_nak", rx_q[base+3], 8'hEE);

        // capture-done flag
        @(negedge clk); set_capture_done = 1'b1;
        @(negedge clk); set_capture_done = 1'b0;
        chk("capdone_set", regs[7:0], 8'h20);
        issue(16'h4000, 0); wait_idle();
        chk("capdone_clr", regs[7:0], 8'h00);
        issue(16'h4001, 1); wait_idle();
        chk("capdone_simul", regs[7:0], 8'h21);

        // dump with wrap, then bad channel
        base = rx_q.size();
        issue(16'h8200, 0); wait_idle();
        if (DUMP_ON) begin
            chk("dump_len", rx_q.size() - base, 8);
            for (int i = 0; i < 8; i++) chk("dump_byte", rx_q[base+i], dump_exp[i]);
        end else chk("dump_disabled_nak", rx_q[base], 8'hEE);
        base = rx_q.size();
        issue(16'h8700, 0); wait_idle();
        chk("bad_ch_nak", rx_q[base], 8'hEE);

        // cmd_rdy held during a dump is taken only after the last byte
        base = rx_q.size();
        issue(16'h8200, 0);
        issue(16'h0300, 0);
        chk("held_cmd_after_dump", rx_q.size() - base, DUMP_ON ? 8 : 1);
        wait_idle();

        // reset during a dump (or a handshake without dumps)
        base = rx_q.size();
        issue(16'h8200, 0);
        begin
            int t = 0;
            int need = DUMP_ON ? 3 : 1;
            while (rx_q.size() < base + need && t < 500) begin @(negedge clk); t++; end
            chk("third_byte_seen", rx_q.size() >= base + need, 1);
            rst = 1'b1; @(negedge clk); rst = 1'b0;
            chk("busy_after_reset", busy, 0);
            repeat (20) @(negedge clk);
            chk("no_send_after_reset", rx_q.size() - base, need);
        end

        // randomized commands
        for (int n = 0; n < 60; n++) begin
            logic [1:0] op;
            int idx;
            op = 2'($urandom_range(0, 3));
            idx = (op == 2'b10) ? $urandom_range(0, 7) : $urandom_range(0, 19);
            cap_start_addr = 3'($urandom);
            issue({op, 6'(idx), 8'($urandom)}, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 0) wait_idle();
        end
        wait_idle();
        repeat (6) @(negedge clk);
        chk("model_queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_la_cmd_ctrl
`default_nettype wire
